// File: rtl/sw_debounce.sv
// Per-channel switch debouncer: 2-flop synchronizer, then a two-state FSM with a stability counter per bit.
// The debounced level plus registered rise/fall/changed pulses are produced in the same cycle the level updates.
module sw_debounce #(
    parameter int NUM_SW          = 9,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_db,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sw_changed
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

    logic [NUM_SW-1:0] meta_q;
    logic [NUM_SW-1:0] sync_q;

    state_e            state_q [NUM_SW];
    logic [CW-1:0]     cnt_q   [NUM_SW];
    logic [NUM_SW-1:0] db_q;
    logic [NUM_SW-1:0] rise_q;
    logic [NUM_SW-1:0] fall_q;
    logic              changed_q;

    logic [NUM_SW-1:0] accept_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= sw_in;
            sync_q <= meta_q;
        end
    end

    // A bit is accepted on the edge where its counter already sits at the last value and sync still disagrees.
    always_comb begin
        accept_d = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            accept_d[i] = (state_q[i] == ST_COUNTING) &&
                          (sync_q[i] != db_q[i]) &&
                          (cnt_q[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SW; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            db_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                case (state_q[i])
                    ST_STABLE: begin
                        if (sync_q[i] != db_q[i]) begin
                            state_q[i] <= ST_COUNTING;
                            cnt_q[i]   <= CNT_ONE;
                        end
                    end
                    ST_COUNTING: begin
                        if ((sync_q[i] == db_q[i]) || (cnt_q[i] == CNT_LAST)) begin
                            state_q[i] <= ST_STABLE;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                endcase
            end
            db_q      <= db_q ^ accept_d;
            rise_q    <= accept_d & sync_q;
            fall_q    <= accept_d & ~sync_q;
            changed_q <= |accept_d;
        end
    end

    assign sw_db      = db_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed latency/bounce/reset scenarios plus randomized bouncing inputs
// checked against a sliding-window model (accept when the last D synchronized samples all oppose sw_db).
module tb_sw_debounce;

    localparam int N = 9;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw_in = '0;
    logic [N-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_changed;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sw_debounce #(.NUM_SW(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    // Reference model: two-stage sample delay, then a window of the last D synchronized samples.
    logic [N-1:0] m_meta, m_sync, m_db, m_rise, m_fall;
    logic         m_chg;
    logic [N-1:0] m_hist [D];

    function automatic logic [N-1:0] window_accept();
        logic [N-1:0] acc;
        acc = '1;
        for (int k = 0; k < D; k++) acc = acc & (m_hist[k] ^ m_db);
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_meta <= '0;
            m_sync <= '0;
            m_db   <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_chg  <= 1'b0;
            for (int k = 0; k < D; k++) m_hist[k] <= '0;
        end else begin
            m_rise <= window_accept() & ~m_db;
            m_fall <= window_accept() & m_db;
            m_chg  <= |window_accept();
            m_db   <= m_db ^ window_accept();
            m_meta <= sw_in;
            m_sync <= m_meta;
            m_hist[0] <= m_meta;
            for (int k = 1; k < D; k++) m_hist[k] <= m_hist[k-1];
        end
    end

    task automatic do_reset(input logic [N-1:0] v);
        @(negedge clk);
        rst_n = 1'b0;
        sw_in = v;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset('0);
        sw_in = 9'h0AA;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sw_db !== 9'h0AA) begin
            n_err++;
            $display("FAIL reset_pre: sw_db got %h want %h", sw_db, 9'h0AA);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sw_db, sw_rise, sw_fall, sw_changed} !== '0) begin
            n_err++;
            $display("FAIL reset_async: db=%h rise=%h fall=%h chg=%b want all 0",
                     sw_db, sw_rise, sw_fall, sw_changed);
        end
        @(negedge clk);
        n_cmp++;
        if ({sw_db, sw_rise, sw_fall, sw_changed} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: db=%h rise=%h fall=%h chg=%b want all 0",
                     sw_db, sw_rise, sw_fall, sw_changed);
        end
        rst_n = 1'b1;
    endtask

    // Bit 0 held high through reset release; first edge after release is edge 1.
    task automatic test_rise_single();
        logic [N-1:0] e_db, e_rise;
        do_reset(9'h001);
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            e_db   = (e >= 6) ? 9'h001 : 9'h000;
            e_rise = (e == 6) ? 9'h001 : 9'h000;
            n_cmp++;
            if ({sw_db, sw_rise, sw_fall, sw_changed} !== {e_db, e_rise, 9'h000, (e == 6)}) begin
                n_err++;
                $display("FAIL rise_single e=%0d: got db=%h rise=%h fall=%h chg=%b want db=%h rise=%h fall=000 chg=%b",
                         e, sw_db, sw_rise, sw_fall, sw_changed, e_db, e_rise, (e == 6));
            end
        end
    endtask

    task automatic test_bounce();
        sw_in = 9'h000;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            n_cmp++;
            if ({sw_db, sw_rise, sw_fall, sw_changed} !== {9'h001, 9'h000, 9'h000, 1'b0}) begin
                n_err++;
                $display("FAIL bounce e=%0d: got db=%h rise=%h fall=%h chg=%b want db=001 rise=000 fall=000 chg=0",
                         e, sw_db, sw_rise, sw_fall, sw_changed);
            end
            if (e == 3) sw_in = 9'h001;
        end
    endtask

    task automatic test_all_rise();
        int pulses;
        logic [N-1:0] e_db, e_rise;
        pulses = 0;
        do_reset('0);
        repeat (2) @(negedge clk);
        sw_in = 9'h1FF;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (sw_changed === 1'b1) pulses++;
            e_db   = (e >= 6) ? 9'h1FF : 9'h000;
            e_rise = (e == 6) ? 9'h1FF : 9'h000;
            n_cmp++;
            if ({sw_db, sw_rise, sw_fall} !== {e_db, e_rise, 9'h000}) begin
                n_err++;
                $display("FAIL all_rise e=%0d: got db=%h rise=%h fall=%h want db=%h rise=%h fall=000",
                         e, sw_db, sw_rise, sw_fall, e_db, e_rise);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL all_rise_chg: changed pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_all_fall();
        logic [N-1:0] e_db, e_fall;
        do_reset(9'h0FF);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (sw_db !== 9'h0FF) begin
            n_err++;
            $display("FAIL all_fall_pre: sw_db got %h want 0ff", sw_db);
        end
        sw_in = 9'h000;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            e_db   = (e >= 6) ? 9'h000 : 9'h0FF;
            e_fall = (e == 6) ? 9'h0FF : 9'h000;
            n_cmp++;
            if ({sw_db, sw_rise, sw_fall, sw_changed} !== {e_db, 9'h000, e_fall, (e == 6)}) begin
                n_err++;
                $display("FAIL all_fall e=%0d: got db=%h rise=%h fall=%h chg=%b want db=%h rise=000 fall=%h chg=%b",
                         e, sw_db, sw_rise, sw_fall, sw_changed, e_db, e_fall, (e == 6));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] e_db, e_rise;
        do_reset(9'h1F0);
        repeat (8) @(negedge clk);
        sw_in = 9'h1F8;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            n_cmp++;
            if (sw_db !== 9'h1F0) begin
                n_err++;
                $display("FAIL mid_pre e=%0d: sw_db got %h want 1f0", e, sw_db);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sw_db, sw_rise, sw_fall, sw_changed} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: db=%h rise=%h fall=%h chg=%b want all 0",
                     sw_db, sw_rise, sw_fall, sw_changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            e_db   = (e >= 6) ? 9'h1F8 : 9'h000;
            e_rise = (e == 6) ? 9'h1F8 : 9'h000;
            n_cmp++;
            if ({sw_db, sw_rise, sw_fall} !== {e_db, e_rise, 9'h000}) begin
                n_err++;
                $display("FAIL mid_after e=%0d: got db=%h rise=%h fall=%h want db=%h rise=%h fall=000",
                         e, sw_db, sw_rise, sw_fall, e_db, e_rise);
            end
        end
    endtask

    task automatic test_random();
        int den;
        int accepts;
        logic [N-1:0] flip;
        accepts = 0;
        do_reset('0);
        for (int seg = 0; seg < 30; seg++) begin
            case (seg % 3)
                0:       den = 2;
                1:       den = 8;
                default: den = 30;
            endcase
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (m_chg === 1'b1) accepts++;
                n_cmp++;
                if ({sw_db, sw_rise, sw_fall, sw_changed} !== {m_db, m_rise, m_fall, m_chg}) begin
                    n_err++;
                    $display("FAIL random seg=%0d c=%0d: got db=%h rise=%h fall=%h chg=%b want db=%h rise=%h fall=%h chg=%b",
                             seg, c, sw_db, sw_rise, sw_fall, sw_changed, m_db, m_rise, m_fall, m_chg);
                end
                rst_n = ($urandom_range(399) == 0) ? 1'b0 : 1'b1;
                for (int b = 0; b < N; b++) flip[b] = ($urandom_range(den - 1) == 0);
                sw_in = sw_in ^ flip;
            end
        end
        rst_n = 1'b1;
        n_cmp++;
        if (accepts == 0) begin
            n_err++;
            $display("FAIL random_activity: accepted changes got 0 want >0");
        end
    endtask

    initial begin
        test_reset();
        test_rise_single();
        test_bounce();
        test_all_rise();
        test_all_fall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The module SHALL have parameter NUM_SW, default 9, giving the number of switch channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), giving the stable-input cycles required to accept a change; legal range 2..2^20.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port sw_in, input, NUM_SW bits: raw asynchronous board switch levels.
REQ-006 The module SHALL have port sw_db, output, NUM_SW bits: debounced switch levels, registered, feeding the downstream led/gpio1 mapping.
REQ-007 The module SHALL have port sw_rise, output, NUM_SW bits: one-cycle pulse per bit when sw_db goes 0->1.
REQ-008 The module SHALL have port sw_fall, output, NUM_SW bits: one-cycle pulse per bit when sw_db goes 1->0.
REQ-009 The module SHALL have port sw_changed, output, 1 bit: one-cycle pulse, OR of all sw_rise and sw_fall bits in the same cycle.

Function
REQ-010 Each sw_in bit SHALL pass through a 2-flop synchronizer; only the second flop (sync bit) drives downstream logic.
REQ-011 Each bit SHALL own an independent counter of width clog2(DEBOUNCE_CYCLES+1); no bit affects another.
REQ-012 Per-bit FSM SHALL have two states: STABLE (sync == sw_db, counter 0) and COUNTING (sync != sw_db).
REQ-013 In STABLE, a cycle with sync != sw_db SHALL move to COUNTING with counter incremented to 1.
REQ-014 In COUNTING, sync != sw_db with counter < DEBOUNCE_CYCLES-1 SHALL increment counter by 1.
REQ-015 In COUNTING, sync == sw_db (bounce back) SHALL clear counter to 0 and return to STABLE with no output change.
REQ-016 In COUNTING, sync != sw_db with counter == DEBOUNCE_CYCLES-1 SHALL load sw_db with sync, clear counter, return to STABLE.
REQ-017 Latency: a clean sw_in change SHALL appear on sw_db at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge sampling the new level as edge 1.
REQ-018 Any sync excursion lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave sw_db, sw_rise, sw_fall, sw_changed unchanged.
REQ-019 sw_rise/sw_fall SHALL be registered and assert in exactly the cycle sw_db first shows the new value, for exactly one cycle.
REQ-020 Simultaneous accepted changes on several bits SHALL pulse all corresponding rise/fall bits in the same cycle, with a single-cycle sw_changed.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-022 A bit held at 1 through reset release SHALL be accepted as a normal 0->1 change, producing sw_rise after DEBOUNCE_CYCLES+2 edges.

Reset
REQ-023 rst_n low SHALL immediately, without clock, clear synchronizer flops, counters, sw_db, sw_rise, sw_fall, sw_changed to 0 and force every FSM to STABLE.
REQ-024 Reset asserted mid-COUNTING SHALL discard the count; after release counting restarts from 0.
REQ-025 The first rising edge with rst_n high SHALL be treated as a normal sampling edge.

Verification (DEBOUNCE_CYCLES=4, NUM_SW=9)
REQ-026 Reset then sw_in=9'h001 held -> sw_db=9'h001 at edge 6, sw_rise=9'h001 and sw_changed=1 for that cycle only.
REQ-027 sw_db=9'h001, sw_in[0] low for 3 cycles then high -> sw_db, sw_fall, sw_changed stay constant/0 throughout.
REQ-028 sw_in=9'h000 -> 9'h1FF in one cycle -> sw_db=9'h1FF at edge 6, sw_rise=9'h1FF, one sw_changed pulse.
REQ-029 sw_in[3] rises, rst_n pulsed low at edge 4 -> all outputs 0 immediately; sw_db[3]=1 exactly 6 edges after release.
REQ-030 sw_db=9'h0FF, sw_in=9'h000 -> sw_db=9'h000 at edge 6, sw_fall=9'h0FF one cycle, sw_rise=0.
